envelope_avg_unit: RTL

Produces the `env_avg` envelope estimate consumed by the cutoff-frequency mapping stage. It sits between the audio sample stream and the cutoff stage and works in three steps:
- full-wave rectifies signed samples;
- block-averages them over a power-of-two window;
- smooths the result with instant attack and shift-based release.

A one-cycle `env_valid` strobe marks each new estimate, so downstream logic can register cutoff updates at window rate.

---
 rtl/envelope_avg_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/envelope_avg_unit.sv
// -----------------------------------------------------------------------------
// envelope_avg_unit
//
// Envelope follower feeding the cutoff-frequency mapping stage:
//   1. full-wave rectifies signed audio samples (most-negative saturates),
//   2. block-averages 2**WIN_LOG2 accepted samples,
//   3. smooths the window average with instant attack and shift-based release.
//
// Handshake: sample_valid is a plain valid strobe with no ready. A sample is
// accepted on every rising edge where sample_valid && enable. env_valid is a
// one-cycle pulse on the cycle env_avg takes a new value; env_avg is stable
// between pulses.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   enable        in   low flushes the partial window and holds the envelope
//   sample_in     in   SAMPLE_WIDTH signed two's-complement sample
//   sample_valid  in   sample_in valid this cycle
//   env_avg       out  SAMPLE_WIDTH unsigned envelope (MSB always 0)
//   env_valid     out  one-cycle pulse marking a new env_avg
//   dbg_state     out  FSM state (0 IDLE, 1 ACCUM, 2 UPDATE) for checkers
// -----------------------------------------------------------------------------
module envelope_avg_unit #(
  parameter int SAMPLE_WIDTH  = 24,
  parameter int WIN_LOG2      = 6,
  parameter int RELEASE_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic [SAMPLE_WIDTH-1:0] env_avg,
  output logic                    env_valid,
  output logic [1:0]              dbg_state
);

  localparam int MW = SAMPLE_WIDTH - 1;   // magnitude width
  localparam int AW = MW + WIN_LOG2;      // accumulator width, never overflows
  localparam logic [WIN_LOG2-1:0]     CNT_LAST = '1;
  localparam logic [WIN_LOG2-1:0]     CNT_ONE  = {{(WIN_LOG2-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0]           MAG_ONE  = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [SAMPLE_WIDTH-1:0] ENV_ONE  = {{(SAMPLE_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [WIN_LOG2-1:0]     cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] win_q, win_d;
  logic [SAMPLE_WIDTH-1:0] env_q, env_d;
  logic                    env_valid_q;

  logic          accept;
  logic          win_close;
  logic          upd_en;
  logic [MW-1:0] mag;
  logic [MW-1:0] neg_mag;
  logic [AW-1:0] sum;
  logic [SAMPLE_WIDTH-1:0] diff;
  logic [SAMPLE_WIDTH-1:0] step;

  assign accept    = sample_valid & enable;
  assign win_close = accept & (cnt_q == CNT_LAST);

  // Low MW bits of the negated sample are exact for every negative input
  // except the most-negative one, whose low bits are all zero.
  assign neg_mag = (~sample_in[MW-1:0]) + MAG_ONE;

  always_comb begin
    if (!sample_in[SAMPLE_WIDTH-1]) begin
      mag = sample_in[MW-1:0];
    end else if (sample_in[MW-1:0] == '0) begin
      mag = '1;
    end else begin
      mag = neg_mag;
    end
  end

  assign sum = acc_q + {{WIN_LOG2{1'b0}}, mag};

  // Accumulator path: independent of the smoothing path, so a sample
  // arriving during UPDATE starts the next window.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    win_d = win_q;
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (win_close) begin
        win_d = {1'b0, sum[AW-1:WIN_LOG2]};
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_ACCUM;
      ST_ACCUM: begin
        if (!enable)        state_d = ST_IDLE;
        else if (win_close) state_d = ST_UPDATE;
      end
      ST_UPDATE: state_d = enable ? ST_ACCUM : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    upd_en = (state_q == ST_UPDATE);
  end

  // Smoothing: instant attack, release by (env - avg) >> RELEASE_SHIFT with a
  // floor of 1 so the envelope always reaches the window average.
  assign diff = env_q - win_q;

  always_comb begin
    step = diff >> RELEASE_SHIFT;
    if (step == '0) step = ENV_ONE;
  end

  always_comb begin
    env_d = env_q;
    if (upd_en) begin
      if (win_q >= env_q) env_d = win_q;
      else                env_d = env_q - step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      win_q       <= '0;
      env_q       <= '0;
      env_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      env_q       <= env_d;
      env_valid_q <= upd_en;
    end
  end

  assign env_avg   = env_q;
  assign env_valid = env_valid_q;
  assign dbg_state = state_q;

endmodule
